// File: rtl/dice_pkg.sv
// dice_pkg: shared widths, LFSR constants, roll FSM encoding and helpers for
// the dice front-end (dice_roll_unit, btn_debounce).
package dice_pkg;

  localparam int DICE_W    = 3;
  localparam int LFSR_W    = 16;
  localparam int TRY_W     = 3;
  localparam int MAX_TRIES = 7;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;
  // Feedback taps: b0, b2, b3, b5.
  localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'h002D;

  typedef enum logic {IDLE, DRAW} roll_state_t;

  // Per-player result as seen by the display/scoring stage.
  typedef struct packed {
    logic              rolled;
    logic [DICE_W-1:0] dice;
  } roll_rsp_t;

  // Fibonacci step: shift right, XOR of tapped bits enters at the MSB.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchronizer, stability counter and rising-edge
// detector for one raw push-button.
//   clk, rst_n : clock, async active-low reset
//   btn_raw    : raw button level, asynchronous to clk
//   press      : one-cycle pulse on each accepted press (release is silent)
module btn_debounce #(
  parameter int DEB_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam int CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

  logic             sync1, sync2;
  logic             level, level_q;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= btn_raw;
      sync2   <= sync1;
      level_q <= level;
      // Any cycle that agrees with the accepted level restarts the count,
      // so only DEB_CYCLES consecutive disagreeing samples flip it.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = level & ~level_q;

endmodule

// File: rtl/dice_roll_unit.sv
// dice_roll_unit: two-player dice front-end. Debounces both buttons, keeps a
// free-running 16-bit LFSR and runs one IDLE/DRAW roll FSM per player.
//   clk, rst_n     : clock, async active-low reset
//   btn1, btn2     : raw player buttons (active-high, asynchronous)
//   dice1, dice2   : last rolled value 1..6, 0 until first roll after reset
//   rolled1/2      : one-cycle strobe, dice* is new in this cycle
module dice_roll_unit
  import dice_pkg::*;
#(
  parameter int                DEB_CYCLES = 1000,
  parameter logic [LFSR_W-1:0] SEED       = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn1,
  input  logic              btn2,
  output logic [DICE_W-1:0] dice1,
  output logic [DICE_W-1:0] dice2,
  output logic              rolled1,
  output logic              rolled2
);

  localparam int NUM_LANES = 2;
  // Lane g samples lfsr[8g+2:8g]; disjoint bits keep simultaneous rolls independent.
  localparam int SAMPLE_STRIDE = 8;

  logic [NUM_LANES-1:0] btn_raw, press;
  logic [LFSR_W-1:0]    lfsr;
  roll_rsp_t [NUM_LANES-1:0] rsp;

  assign btn_raw = {btn2, btn1};

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb [NUM_LANES-1:0] (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_raw),
    .press   (press)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= SEED;
    else        lfsr <= lfsr_next(lfsr);
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    roll_state_t       state_q, state_d;
    logic [TRY_W-1:0]  try_q, try_d;
    logic [DICE_W-1:0] dice_q, dice_d, sample;
    logic              rolled_q, rolled_d;

    assign sample = lfsr[g*SAMPLE_STRIDE +: DICE_W];

    always_comb begin
      state_d  = state_q;
      try_d    = try_q;
      dice_d   = dice_q;
      rolled_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (press[g]) begin
            state_d = DRAW;
            try_d   = '0;
          end
        end
        DRAW: begin
          // Presses arriving here are dropped, not queued.
          if (sample != '0 && sample != '1) begin
            dice_d   = sample;
            rolled_d = 1'b1;
            state_d  = IDLE;
          end else if (try_q == TRY_W'(MAX_TRIES)) begin
            // Last try: clamp 0 -> 1 and 7 -> 6 so a roll always completes.
            dice_d   = (sample == '0) ? DICE_W'(1) : DICE_W'(6);
            rolled_d = 1'b1;
            state_d  = IDLE;
          end else begin
            try_d = try_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q  <= IDLE;
        try_q    <= '0;
        dice_q   <= '0;
        rolled_q <= 1'b0;
      end else begin
        state_q  <= state_d;
        try_q    <= try_d;
        dice_q   <= dice_d;
        rolled_q <= rolled_d;
      end
    end

    assign rsp[g] = '{rolled: rolled_q, dice: dice_q};
  end

  assign dice1   = rsp[0].dice;
  assign rolled1 = rsp[0].rolled;
  assign dice2   = rsp[1].dice;
  assign rolled2 = rsp[1].rolled;

endmodule

// File: tb/tb_dice_roll_unit.sv
module tb_dice_roll_unit;
  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst_n, btn1, btn2;
  logic [2:0] dice1, dice2;
  logic       rolled1, rolled2;

  dice_roll_unit #(.DEB_CYCLES(DEB), .SEED(16'hACE1)) dut (
    .clk(clk), .rst_n(rst_n), .btn1(btn1), .btn2(btn2),
    .dice1(dice1), .dice2(dice2), .rolled1(rolled1), .rolled2(rolled2)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Software LFSR: right shift, feedback bit15 = b0^b2^b3^b5.
  function automatic logic [15:0] sw_lfsr(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return (s >> 1) | ({15'd0, fb} << 15);
  endfunction

  // ---------------- behavioural model ----------------
  // Cycle-indexed: cyc counts clock edges since reset release. A press seen
  // in cycle c draws from the LFSR values of cycles c+1..c+8 and strobes the
  // cycle after the accepted sample; the player is busy until then.
  int          cyc;
  logic [15:0] m_lfsr;
  bit          bd1 [2], bd2 [2], lvl [2], pend [2], exp_rolled [2];
  int          run [2], strobe_at [2], busy_until [2];
  logic [2:0]  pval [2], exp_dice [2];

  task automatic m_reset();
    cyc = 0;
    m_lfsr = 16'hACE1;
    for (int p = 0; p < 2; p++) begin
      bd1[p] = 0; bd2[p] = 0; lvl[p] = 0; pend[p] = 0; exp_rolled[p] = 0;
      run[p] = 0; strobe_at[p] = 0; busy_until[p] = -1;
      pval[p] = 0; exp_dice[p] = 0;
    end
  endtask

  task automatic m_draw(input int p);
    logic [15:0] l;
    logic [2:0]  v;
    bit          done;
    l = m_lfsr;
    done = 0;
    for (int t = 0; t < 8; t++) begin
      if (!done) begin
        l = sw_lfsr(l);
        v = (p == 0) ? l[2:0] : l[10:8];
        if (v >= 1 && v <= 6) done = 1;
        else if (t == 7) begin v = (v == 0) ? 3'd1 : 3'd6; done = 1; end
        if (done) begin
          pval[p] = v;
          strobe_at[p] = cyc + 2 + t;
          busy_until[p] = cyc + 1 + t;
          pend[p] = 1;
        end
      end
    end
  endtask

  initial begin
    bit sp, b;
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else begin
        cyc++;
        m_lfsr = sw_lfsr(m_lfsr);
        for (int p = 0; p < 2; p++) begin
          exp_rolled[p] = 0;
          if (pend[p] && cyc == strobe_at[p]) begin
            exp_rolled[p] = 1; exp_dice[p] = pval[p]; pend[p] = 0;
          end
          // synced sample of the previous cycle = raw button two edges ago
          b = (p == 0) ? btn1 : btn2;
          sp = bd2[p]; bd2[p] = bd1[p]; bd1[p] = b;
          if (sp != lvl[p]) begin
            run[p]++;
            if (run[p] == DEB) begin
              lvl[p] = ~lvl[p]; run[p] = 0;
              if (lvl[p] && cyc > busy_until[p]) m_draw(p);
            end
          end else run[p] = 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int  n_roll [2];
  int  hist [8];
  int  bad_val = 0;
  bit  prev_r1 = 0;
  initial begin
    for (int i = 0; i < 8; i++) hist[i] = 0;
    n_roll[0] = 0; n_roll[1] = 0;
    forever begin
      @(negedge clk);
      check("rolled1", int'(rolled1), int'(exp_rolled[0]));
      check("rolled2", int'(rolled2), int'(exp_rolled[1]));
      check("dice1", int'(dice1), int'(exp_dice[0]));
      check("dice2", int'(dice2), int'(exp_dice[1]));
      if (rolled1) begin
        check("rolled1_width", int'(prev_r1), 0);
        n_roll[0]++;
        hist[dice1]++;
        if (dice1 == 0 || dice1 == 7) bad_val++;
      end
      if (rolled2) n_roll[1]++;
      prev_r1 = rolled1;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, r1;
    logic [15:0] s;
    rst_n = 0; btn1 = 0; btn2 = 0;
    tick(3);
    check("rst_dice1", int'(dice1), 0);
    check("rst_dice2", int'(dice2), 0);
    check("rst_rolled", int'(rolled1 | rolled2), 0);

    // Pin the model: 9 steps from ACE1 by hand = 9156.
    s = 16'hACE1;
    for (int i = 0; i < 9; i++) s = sw_lfsr(s);
    check("model_lfsr9", int'(s), 16'h9156);

    // Release reset and raise btn1 in the same cycle (cycle 0).
    rst_n = 1; btn1 = 1;
    check("lfsr_c0", int'(dut.lfsr), 16'hACE1);
    check("model_c0", int'(m_lfsr), 16'hACE1);
    tick(1);
    check("lfsr_c1", int'(dut.lfsr), 16'h5670);
    // Press in cycle 6; DRAW cycle 7 samples 16'h4559 -> 1, strobe in cycle 8.
    tick(6);
    check("first_roll_c7", int'(rolled1), 0);
    tick(1);
    check("first_roll_c8", int'(rolled1), 1);
    check("first_dice", int'(dice1), 1);
    tick(12); btn1 = 0;   // held 20 cycles in total
    tick(20);
    check("held_one_roll", n_roll[0], 1);

    // Glitch of 3 cycles on btn2: no event.
    r1 = n_roll[1];
    btn2 = 1; tick(3); btn2 = 0; tick(20);
    check("glitch_no_roll", n_roll[1] - r1, 0);
    check("glitch_dice2", int'(dice2), 0);
    btn2 = 1; tick(10); btn2 = 0; tick(20);
    check("pulse10_roll", n_roll[1] - r1, 1);
    check("pulse10_range", int'(dice2 >= 1 && dice2 <= 6), 1);

    // Simultaneous press.
    r0 = n_roll[0]; r1 = n_roll[1];
    btn1 = 1; btn2 = 1; tick(12); btn1 = 0; btn2 = 0; tick(20);
    check("simul_roll1", n_roll[0] - r0, 1);
    check("simul_roll2", n_roll[1] - r1, 1);

    // Reset during DRAW.
    r0 = n_roll[0];
    btn1 = 1;
    for (int k = 0; k < 30 && !pend[0]; k++) tick(1);
    check("draw_press_seen", int'(pend[0]), 1);
    tick(1);
    rst_n = 0; btn1 = 0;
    tick(2);
    rst_n = 1;
    tick(30);
    check("rst_draw_no_roll", n_roll[0] - r0, 0);
    check("rst_draw_dice1", int'(dice1), 0);

    // Distribution: 600 rolls on btn1.
    r0 = n_roll[0];
    for (int i = 0; i < 8; i++) hist[i] = 0;
    for (int i = 0; i < 600; i++) begin
      btn1 = 1; tick(12); btn1 = 0; tick(10);
    end
    tick(20);
    check("dist_count", n_roll[0] - r0, 600);
    for (int v = 1; v <= 6; v++) check($sformatf("dist_seen_%0d", v), int'(hist[v] > 0), 1);
    check("dist_out_of_range", bad_val, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
